// File: rtl/ccnet_pkg.sv
// Shared CCNET framing constants, scheduler state/requester types and the
// byte-serial CRC-16 helper used by both transmit and receive paths.
package ccnet_pkg;

  localparam logic [7:0]  SYNC       = 8'h02;
  localparam logic [7:0]  CMD_RESET  = 8'h30;
  localparam logic [7:0]  CMD_POLL   = 8'h33;
  localparam logic [7:0]  CMD_ACK    = 8'h00;
  localparam logic [7:0]  CMD_ENABLE = 8'h34;
  localparam logic [3:0]  LNG_SHORT  = 4'd6;
  localparam logic [3:0]  LNG_ENABLE = 4'd12;
  localparam logic [15:0] CRC_POLY   = 16'h8408;

  // Requester indices double as bit positions in the done vector.
  typedef enum logic [1:0] {
    REQ_RESET  = 2'd0,
    REQ_ACK    = 2'd1,
    REQ_POLL   = 2'd2,
    REQ_ENABLE = 2'd3
  } reqSel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_GAP     = 3'd5
  } txState_t;

  function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn, input logic [7:0] data);
    logic [15:0] c;
    c = crcIn ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[15:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ccnet_crc16_byte.sv
// Combinational CCNET CRC-16 step: folds one byte into a running CRC.
module ccnet_crc16_byte
  import ccnet_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // next CRC for the presented byte
  always_comb begin
    crc_out = crc16Byte(crc_in, data);
  end

endmodule

// File: rtl/ccnet_tx_scheduler.sv
// Arbitrates CCNET command requests onto the shared UART transmitter, building
// each frame on the fly and enforcing an idle gap between frames.
module ccnet_tx_scheduler
  import ccnet_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR   = 8'h03,
  parameter int         GAP_CYCLES = 20000,
  parameter int         BUSY_TO    = 16
) (
  input  logic        CLK_10MHZ,
  input  logic        rst,
  input  logic        req_reset,
  input  logic        req_ack,
  input  logic        req_enable,
  input  logic        req_poll,
  input  logic [23:0] bill_enable_mask,
  input  logic [23:0] escrow_mask,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [3:0]  done,
  output logic        err,
  output logic        active
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    TO_LAST  = 5'(BUSY_TO - 1);

  txState_t       state_r, stateNext_s;
  reqSel_t        sel_r, selNext_s;
  logic [3:0]     lng_r, lngNext_s;
  logic [3:0]     idx_r, idxNext_s;
  logic [15:0]    crc_r, crcNext_s, crcUpd_s;
  logic [23:0]    enMask_r, enMaskNext_s;
  logic [23:0]    esMask_r, esMaskNext_s;
  logic [GW-1:0]  gapCnt_r, gapCntNext_s;
  logic [4:0]     toCnt_r, toCntNext_s;
  logic           txStart_r, txStartNext_s;
  logic [7:0]     txData_r, txDataNext_s;
  logic [3:0]     done_r, doneNext_s;
  logic           err_r, errNext_s;
  logic           active_r, activeNext_s;
  logic [7:0]     curByte_s, cmdByte_s, dataByte_s;
  logic [3:0]     dataIdx_s;
  logic           anyReq_s;

  ccnet_crc16_byte uCrc (
    .crc_in  (crc_r),
    .data    (curByte_s),
    .crc_out (crcUpd_s)
  );

  // byte map: header, data from latched masks, then CRC low/high
  always_comb begin
    dataIdx_s = idx_r - 4'd4;
    case (sel_r)
      REQ_RESET:  cmdByte_s = CMD_RESET;
      REQ_ACK:    cmdByte_s = CMD_ACK;
      REQ_POLL:   cmdByte_s = CMD_POLL;
      REQ_ENABLE: cmdByte_s = CMD_ENABLE;
      default:    cmdByte_s = CMD_POLL;
    endcase
    case (dataIdx_s)
      4'd0:    dataByte_s = enMask_r[23:16];
      4'd1:    dataByte_s = enMask_r[15:8];
      4'd2:    dataByte_s = enMask_r[7:0];
      4'd3:    dataByte_s = esMask_r[23:16];
      4'd4:    dataByte_s = esMask_r[15:8];
      4'd5:    dataByte_s = esMask_r[7:0];
      default: dataByte_s = 8'h00;
    endcase
    if (idx_r == 4'd0) begin
      curByte_s = SYNC;
    end else if (idx_r == 4'd1) begin
      curByte_s = DEV_ADDR;
    end else if (idx_r == 4'd2) begin
      curByte_s = {4'd0, lng_r};
    end else if (idx_r == 4'd3) begin
      curByte_s = cmdByte_s;
    end else if (idx_r == lng_r - 4'd2) begin
      curByte_s = crc_r[7:0];
    end else if (idx_r == lng_r - 4'd1) begin
      curByte_s = crc_r[15:8];
    end else begin
      curByte_s = dataByte_s;
    end
  end

  // next-state and next-output logic
  always_comb begin
    stateNext_s   = state_r;
    selNext_s     = sel_r;
    lngNext_s     = lng_r;
    idxNext_s     = idx_r;
    crcNext_s     = crc_r;
    enMaskNext_s  = enMask_r;
    esMaskNext_s  = esMask_r;
    gapCntNext_s  = gapCnt_r;
    toCntNext_s   = toCnt_r;
    txStartNext_s = 1'b0;
    txDataNext_s  = txData_r;
    doneNext_s    = 4'b0000;
    errNext_s     = 1'b0;
    activeNext_s  = active_r;
    anyReq_s      = req_reset | req_ack | req_enable | req_poll;

    case (state_r)
      ST_IDLE: begin
        if (anyReq_s && !tx_busy) begin
          if (req_reset) begin
            selNext_s = REQ_RESET;
          end else if (req_ack) begin
            selNext_s = REQ_ACK;
          end else if (req_enable) begin
            selNext_s = REQ_ENABLE;
          end else begin
            selNext_s = REQ_POLL;
          end
          activeNext_s = 1'b1;
          stateNext_s  = ST_LOAD;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        crcNext_s = 16'h0000;
        idxNext_s = 4'd0;
        if (sel_r == REQ_ENABLE) begin
          lngNext_s    = LNG_ENABLE;
          enMaskNext_s = bill_enable_mask;
          esMaskNext_s = escrow_mask;
        end else begin
          lngNext_s = LNG_SHORT;
        end
        stateNext_s = ST_SEND;
      end
      ST_SEND: begin
        txDataNext_s  = curByte_s;
        txStartNext_s = 1'b1;
        if (idx_r < lng_r - 4'd2) begin
          crcNext_s = crcUpd_s;
        end else begin
          crcNext_s = crc_r;
        end
        toCntNext_s = 5'd0;
        stateNext_s = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          stateNext_s = ST_WAIT_LO;
        end else if (toCnt_r == TO_LAST) begin
          errNext_s    = 1'b1;
          activeNext_s = 1'b0;
          gapCntNext_s = '0;
          stateNext_s  = ST_GAP;
        end else begin
          toCntNext_s = toCnt_r + 5'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          idxNext_s = idx_r + 4'd1;
          if (idx_r == lng_r - 4'd1) begin
            case (sel_r)
              REQ_RESET:  doneNext_s = 4'b0001;
              REQ_ACK:    doneNext_s = 4'b0010;
              REQ_POLL:   doneNext_s = 4'b0100;
              REQ_ENABLE: doneNext_s = 4'b1000;
              default:    doneNext_s = 4'b0000;
            endcase
            activeNext_s = 1'b0;
            gapCntNext_s = '0;
            stateNext_s  = ST_GAP;
          end else begin
            stateNext_s = ST_SEND;
          end
        end else begin
          stateNext_s = ST_WAIT_LO;
        end
      end
      ST_GAP: begin
        if (gapCnt_r == GAP_LAST) begin
          stateNext_s = ST_IDLE;
        end else begin
          gapCntNext_s = gapCnt_r + GW'(1);
        end
      end
      default: begin
        activeNext_s = 1'b0;
        gapCntNext_s = '0;
        stateNext_s  = ST_GAP;
      end
    endcase
  end

  // state and output registers; reset drops any frame in flight
  always_ff @(posedge CLK_10MHZ) begin
    if (rst) begin
      state_r   <= ST_GAP;
      sel_r     <= REQ_RESET;
      lng_r     <= LNG_SHORT;
      idx_r     <= 4'd0;
      crc_r     <= 16'h0000;
      enMask_r  <= 24'h000000;
      esMask_r  <= 24'h000000;
      gapCnt_r  <= '0;
      toCnt_r   <= 5'd0;
      txStart_r <= 1'b0;
      txData_r  <= 8'h00;
      done_r    <= 4'b0000;
      err_r     <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      sel_r     <= selNext_s;
      lng_r     <= lngNext_s;
      idx_r     <= idxNext_s;
      crc_r     <= crcNext_s;
      enMask_r  <= enMaskNext_s;
      esMask_r  <= esMaskNext_s;
      gapCnt_r  <= gapCntNext_s;
      toCnt_r   <= toCntNext_s;
      txStart_r <= txStartNext_s;
      txData_r  <= txDataNext_s;
      done_r    <= doneNext_s;
      err_r     <= errNext_s;
      active_r  <= activeNext_s;
    end
  end

  assign tx_start = txStart_r;
  assign tx_data  = txData_r;
  assign done     = done_r;
  assign err      = err_r;
  assign active   = active_r;

endmodule

// File: tb/tb_ccnet_tx_scheduler.sv
// Randomized bench for ccnet_tx_scheduler: frames are rebuilt from the CCNET
// framing rules and compared byte-for-byte, with gap and timeout timing checks.
module tb_ccnet_tx_scheduler;
  localparam int GAP    = 300;
  localparam int BUSYTO = 16;

  logic        CLK_10MHZ = 1'b0;
  logic        rst = 1'b1;
  logic        reqReset = 1'b0, reqAck = 1'b0, reqEnable = 1'b0, reqPoll = 1'b0;
  logic [23:0] billMask = 24'h0, escrowMask = 24'h0;
  logic        txBusy = 1'b0;
  logic        txStart;
  logic [7:0]  txData;
  logic [3:0]  done;
  logic        err;
  logic        active;

  int nChecks = 0, nFails = 0;
  int cyc = 0, frameStartCyc = 0, doneCyc = 0, errCyc = 0, prevEnd = 0;
  bit errSeen = 1'b0;
  logic [7:0] rxQ[$];
  logic [3:0] doneLog[$];

  bit xmitOn = 1'b1;
  int busyLen = 10;
  bit riseNext = 1'b0;
  int busyLeft = 0;

  ccnet_tx_scheduler #(.DEV_ADDR(8'h03), .GAP_CYCLES(GAP), .BUSY_TO(BUSYTO)) dut (
    .CLK_10MHZ(CLK_10MHZ), .rst(rst),
    .req_reset(reqReset), .req_ack(reqAck), .req_enable(reqEnable), .req_poll(reqPoll),
    .bill_enable_mask(billMask), .escrow_mask(escrowMask),
    .tx_busy(txBusy), .tx_start(txStart), .tx_data(txData),
    .done(done), .err(err), .active(active)
  );

  always #50 CLK_10MHZ = ~CLK_10MHZ;

  // UART model: busy rises one cycle after start and stays up busyLen cycles
  always @(posedge CLK_10MHZ) begin
    if (xmitOn && txStart) riseNext <= 1'b1;
    if (riseNext) begin
      riseNext <= 1'b0;
      txBusy   <= 1'b1;
      busyLeft <= busyLen;
    end else if (busyLeft > 1) begin
      busyLeft <= busyLeft - 1;
    end else if (busyLeft == 1) begin
      busyLeft <= 0;
      txBusy   <= 1'b0;
    end
  end

  // output monitor
  always @(negedge CLK_10MHZ) begin
    cyc++;
    if (txStart) begin
      rxQ.push_back(txData);
      if (rxQ.size() == 1) frameStartCyc = cyc;
    end
    if (done != 4'b0000) begin
      doneLog.push_back(done);
      doneCyc = cyc;
    end
    if (err) begin
      errSeen = 1'b1;
      errCyc  = cyc;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_10MHZ);
    #1;
  endtask

  // bit-serial reflected CRC, LSB of each byte first
  function automatic logic [15:0] refCrc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  function automatic logic [3:0] pickWinner(input logic [3:0] r);
    if (r[0]) return 4'b0001;
    if (r[1]) return 4'b0010;
    if (r[3]) return 4'b1000;
    return 4'b0100;
  endfunction

  function automatic void modelFrame(input logic [3:0] w, input logic [23:0] em, input logic [23:0] sm,
                                     output logic [7:0] b[12], output int n);
    logic [15:0] c;
    logic [47:0] d;
    n = (w == 4'b1000) ? 12 : 6;
    b[0] = 8'h02;
    b[1] = 8'h03;
    b[2] = 8'(n);
    case (w)
      4'b0001: b[3] = 8'h30;
      4'b0010: b[3] = 8'h00;
      4'b1000: b[3] = 8'h34;
      default: b[3] = 8'h33;
    endcase
    d = {em, sm};
    for (int k = 0; k < 6; k++) b[4+k] = d[47-8*k -: 8];
    b[10] = 8'h00;
    b[11] = 8'h00;
    c = 16'h0000;
    for (int k = 0; k < n - 2; k++) c = refCrc(c, b[k]);
    b[n-2] = c[7:0];
    b[n-1] = c[15:8];
  endfunction

  // serve one frame for the given request set and check it; returns the winner
  task automatic runFrame(input logic [3:0] reqs, input string tag, output logic [3:0] w);
    logic [7:0] expB[12];
    int expLen, waited, n;
    w = pickWinner(reqs);
    modelFrame(w, billMask, escrowMask, expB, expLen);
    rxQ.delete();
    doneLog.delete();
    errSeen = 1'b0;
    {reqEnable, reqPoll, reqAck, reqReset} = reqs;
    waited = 0;
    while (doneLog.size() == 0 && !errSeen && waited < 4000) begin
      tick();
      waited++;
      if (rxQ.size() > 0) begin
        billMask   = 24'($urandom);
        escrowMask = 24'($urandom);
      end
    end
    checkVal({tag, "_timeout"}, (waited < 4000), 1);
    {reqEnable, reqPoll, reqAck, reqReset} = reqs & ~w;
    repeat (3) tick();
    checkVal({tag, "_len"}, rxQ.size(), expLen);
    n = (rxQ.size() < expLen) ? rxQ.size() : expLen;
    for (int i = 0; i < n; i++) checkVal($sformatf("%s_b%0d", tag, i), rxQ[i], expB[i]);
    checkVal({tag, "_donecnt"}, doneLog.size(), 1);
    if (doneLog.size() > 0) checkVal({tag, "_done"}, doneLog[0], w);
    checkVal({tag, "_noerr"}, errSeen, 0);
    checkVal({tag, "_active"}, active, 0);
    checkVal({tag, "_gap"}, (frameStartCyc - prevEnd >= GAP), 1);
    prevEnd = doneCyc;
  endtask

  initial begin
    logic [3:0] w, reqs;
    logic [3:0] order[4];
    int waited;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0100;

    repeat (3) tick();
    checkVal("rst_txstart", txStart, 0);
    checkVal("rst_txdata", txData, 8'h00);
    checkVal("rst_done", done, 4'b0000);
    checkVal("rst_err", err, 0);
    checkVal("rst_active", active, 0);
    rst = 1'b0;
    prevEnd = cyc;

    runFrame(4'b0001, "reset", w);
    checkVal("reset_crc", {rxQ[5], rxQ[4]}, 16'hB341);
    runFrame(4'b0100, "poll", w);
    checkVal("poll_crc", {rxQ[5], rxQ[4]}, 16'h81DA);
    runFrame(4'b0010, "ack", w);
    checkVal("ack_crc", {rxQ[5], rxQ[4]}, 16'h82C2);
    billMask = 24'h00001C;
    escrowMask = 24'h000000;
    runFrame(4'b1000, "enable", w);
    checkVal("enable_b6", rxQ[6], 8'h1C);

    reqs = 4'hF;
    for (int k = 0; k < 4; k++) begin
      runFrame(reqs, $sformatf("all%0d", k), w);
      checkVal($sformatf("all_order%0d", k), w, order[k]);
      reqs = reqs & ~w;
    end

    // transmitter never answers
    xmitOn = 1'b0;
    rxQ.delete(); doneLog.delete(); errSeen = 1'b0;
    reqPoll = 1'b1;
    waited = 0;
    while (!errSeen && waited < 4000) begin tick(); waited++; end
    reqPoll = 1'b0;
    checkVal("to_seen", errSeen, 1);
    checkVal("to_delay", errCyc - frameStartCyc, BUSYTO);
    checkVal("to_bytes", rxQ.size(), 1);
    repeat (3) tick();
    checkVal("to_nodone", doneLog.size(), 0);
    checkVal("to_active", active, 0);
    xmitOn = 1'b1;
    prevEnd = errCyc;
    runFrame(4'b0010, "after_to", w);

    // reset during byte 3 of a POLL frame
    rxQ.delete(); doneLog.delete();
    reqPoll = 1'b1;
    waited = 0;
    while (rxQ.size() < 4 && waited < 4000) begin tick(); waited++; end
    checkVal("midrst_reach", rxQ.size(), 4);
    rst = 1'b1;
    repeat (2) tick();
    checkVal("midrst_txstart", txStart, 0);
    checkVal("midrst_active", active, 0);
    rst = 1'b0;
    prevEnd = cyc;
    checkVal("midrst_nodone", doneLog.size(), 0);
    runFrame(4'b0100, "resent", w);

    for (int it = 0; it < 6; it++) begin
      reqs = 4'($urandom_range(1, 15));
      busyLen = $urandom_range(1, 12);
      billMask = 24'($urandom);
      escrowMask = 24'($urandom);
      while (reqs != 4'b0000) begin
        runFrame(reqs, $sformatf("rnd%0d", it), w);
        reqs = reqs & ~w;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
